// File: rtl/srv32_mem_arbiter_if.sv
// rtl/srv32_mem_arbiter_if.sv - signal bundle between fetch/data requesters, arbiter and shared memory
interface srv32_mem_arbiter_if;
   // instruction-fetch requester
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_err;
   // data requester
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   // shared memory bus
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_gnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        m_err;
   // arbiter status
   logic        busy;

   // arbiter view: it masters the shared memory bus
   modport master (
      input  i_req, i_addr,
      input  d_req, d_we, d_addr, d_wdata, d_wstrb,
      input  m_gnt, m_rvalid, m_rdata, m_err,
      output i_gnt, i_rvalid, i_rdata, i_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output m_req, m_we, m_addr, m_wdata, m_wstrb,
      output busy
   );

   // environment view: requesters and the memory itself
   modport slave (
      output i_req, i_addr,
      output d_req, d_we, d_addr, d_wdata, d_wstrb,
      output m_gnt, m_rvalid, m_rdata, m_err,
      input  i_gnt, i_rvalid, i_rdata, i_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  m_req, m_we, m_addr, m_wdata, m_wstrb,
      input  busy
   );
endinterface

// File: rtl/srv32_mem_arbiter.sv
// rtl/srv32_mem_arbiter.sv - two-requester round-robin arbiter onto one memory bus, single outstanding transaction
module srv32_mem_arbiter #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                resetb,
   srv32_mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RSP
   } state_t;

   // timeout fires in the WAIT_RSP cycle that would be the TIMEOUT_CYC-th without a response
   localparam logic       TMO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT_CYC - 1) : 8'd0;

   state_t      state;
   logic        owner_d;    // 1: data port owns the transaction, 0: fetch port
   logic        last_d;     // 1: data port was granted most recently
   logic [7:0]  tmo_cnt;
   logic        m_req_q;
   logic        m_we_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wdata_q;
   logic [3:0]  m_wstrb_q;

   logic        pick_d;
   logic        tmo_hit;
   logic        gnt_fire;
   logic        rsp_fire;
   logic        i_fire;
   logic        d_fire;
   logic [31:0] rsp_data;
   logic        rsp_err;

   // data wins when alone, or on conflict when fetch was granted last
   assign pick_d   = bus.d_req & (~bus.i_req | ~last_d);
   assign tmo_hit  = TMO_EN & (tmo_cnt == TMO_LAST);
   assign gnt_fire = (state == WAIT_GNT) & bus.m_gnt;
   // a real response in the timeout cycle takes priority over the forced error
   assign rsp_fire = (state == WAIT_RSP) & (bus.m_rvalid | tmo_hit);
   assign rsp_data = bus.m_rvalid ? bus.m_rdata : 32'h0;
   assign rsp_err  = bus.m_rvalid ? bus.m_err : 1'b1;
   assign i_fire   = rsp_fire & ~owner_d;
   assign d_fire   = rsp_fire & owner_d;

   assign bus.i_gnt    = gnt_fire & ~owner_d;
   assign bus.i_rvalid = i_fire;
   assign bus.i_rdata  = i_fire ? rsp_data : 32'h0;
   assign bus.i_err    = i_fire & rsp_err;
   assign bus.d_gnt    = gnt_fire & owner_d;
   assign bus.d_rvalid = d_fire;
   assign bus.d_rdata  = d_fire ? rsp_data : 32'h0;
   assign bus.d_err    = d_fire & rsp_err;

   assign bus.m_req   = m_req_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.m_wstrb = m_wstrb_q;
   assign bus.busy    = (state != IDLE);

   // arbitration, capture of the owner's request and response tracking
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state     <= IDLE;
         owner_d   <= 1'b0;
         last_d    <= 1'b0;
         tmo_cnt   <= 8'd0;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= 32'h0;
         m_wdata_q <= 32'h0;
         m_wstrb_q <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_req | bus.d_req) begin
                  owner_d   <= pick_d;
                  m_req_q   <= 1'b1;
                  m_we_q    <= pick_d & bus.d_we;
                  m_addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
                  m_wdata_q <= pick_d ? bus.d_wdata : 32'h0;
                  m_wstrb_q <= (pick_d & bus.d_we) ? bus.d_wstrb : 4'h0;
                  state     <= WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               if (bus.m_gnt) begin
                  m_req_q <= 1'b0;
                  last_d  <= owner_d;
                  tmo_cnt <= 8'd0;
                  state   <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (rsp_fire) begin
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_srv32_mem_arbiter.sv
// tb/tb_srv32_mem_arbiter.sv - self-checking bench for srv32_mem_arbiter
module tb_srv32_mem_arbiter;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic resetb;
   int   checks = 0;
   int   passed = 0;

   srv32_mem_arbiter_if bus();

   srv32_mem_arbiter #(.TIMEOUT_CYC(TMO)) dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [69:0] m_bus;
   logic [34:0] i_out;
   logic [34:0] d_out;
   assign m_bus = {bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb};
   assign i_out = {bus.i_gnt, bus.i_rvalid, bus.i_err, bus.i_rdata};
   assign d_out = {bus.d_gnt, bus.d_rvalid, bus.d_err, bus.d_rdata};

   task automatic clear_inputs();
      bus.i_req = 1'b0; bus.i_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;
      bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0; bus.m_err = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      bus.i_req = 1'b1; bus.d_req = 1'b1; bus.m_gnt = 1'b1;
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'hFFFF_FFFF; bus.m_err = 1'b1;
      resetb = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (m_bus !== 70'h0) $display("FAIL reset_m_bus got=%h exp=0", m_bus); else passed++;
      checks++; if (i_out !== 35'h0) $display("FAIL reset_i_out got=%h exp=0", i_out); else passed++;
      checks++; if (d_out !== 35'h0) $display("FAIL reset_d_out got=%h exp=0", d_out); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
      @(negedge clk);
      clear_inputs();
      resetb = 1'b1;
   endtask

   task automatic test_single_fetch();
      @(negedge clk);
      clear_inputs();
      bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.m_gnt = 1'b1;
      #1;
      checks++; if ({bus.busy, bus.m_req} !== 2'b00) $display("FAIL fetch_req_cycle got=%b exp=00", {bus.busy, bus.m_req}); else passed++;
      @(negedge clk); #1;
      checks++; if (m_bus !== {1'b1, 1'b0, 32'h100, 32'h0, 4'h0}) $display("FAIL fetch_m_bus got=%h exp=%h", m_bus, {1'b1, 1'b0, 32'h100, 32'h0, 4'h0}); else passed++;
      checks++; if ({bus.i_gnt, bus.i_rvalid} !== 2'b10) $display("FAIL fetch_i_gnt got=%b exp=10", {bus.i_gnt, bus.i_rvalid}); else passed++;
      checks++; if (d_out !== 35'h0) $display("FAIL fetch_d_quiet_gnt got=%h exp=0", d_out); else passed++;
      @(negedge clk);
      bus.i_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADBEEF; bus.m_err = 1'b0;
      #1;
      checks++; if (i_out !== {1'b0, 1'b1, 1'b0, 32'hDEADBEEF}) $display("FAIL fetch_rsp got=%h exp=%h", i_out, {1'b0, 1'b1, 1'b0, 32'hDEADBEEF}); else passed++;
      checks++; if ({d_out, bus.m_req} !== 36'h0) $display("FAIL fetch_d_quiet_rsp got=%h exp=0", {d_out, bus.m_req}); else passed++;
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if ({bus.busy, i_out} !== 36'h0) $display("FAIL fetch_done got=%h exp=0", {bus.busy, i_out}); else passed++;
   endtask

   task automatic test_write_stall();
      logic [69:0] exp_m;
      exp_m = {1'b1, 1'b1, 32'h2000, 32'h12345678, 4'h3};
      @(negedge clk);
      clear_inputs();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h12345678; bus.d_wstrb = 4'h3;
      #1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         bus.m_gnt = (j == 4);
         if (j > 0) begin
            bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_wstrb = 4'($urandom_range(0, 15));
         end
         #1;
         checks++; if (m_bus !== exp_m) $display("FAIL write_hold[%0d] got=%h exp=%h", j, m_bus, exp_m); else passed++;
         checks++; if ({bus.d_gnt, bus.i_gnt} !== {(j == 4), 1'b0}) $display("FAIL write_gnt[%0d] got=%b exp=%b", j, {bus.d_gnt, bus.i_gnt}, {(j == 4), 1'b0}); else passed++;
      end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         bus.d_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = (c == 3); bus.m_rdata = $urandom; bus.m_err = 1'b0;
         #1;
         checks++; if ({bus.d_gnt, bus.d_rvalid, bus.d_err} !== {1'b0, (c == 3), 1'b0}) $display("FAIL write_rsp[%0d] got=%b exp=%b", c, {bus.d_gnt, bus.d_rvalid, bus.d_err}, {1'b0, (c == 3), 1'b0}); else passed++;
         checks++; if (i_out !== 35'h0) $display("FAIL write_i_quiet[%0d] got=%h exp=0", c, i_out); else passed++;
      end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if (bus.busy !== 1'b0) $display("FAIL write_busy_after got=%b exp=0", bus.busy); else passed++;
   endtask

   task automatic test_timeout();
      logic [34:0] exp_i;
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         clear_inputs();
         bus.i_req = 1'b1; bus.i_addr = 32'h300; bus.m_gnt = 1'b1;
         @(negedge clk); #1;
         checks++; if (bus.i_gnt !== 1'b1) $display("FAIL tmo_gnt[%0d] got=%b exp=1", pass, bus.i_gnt); else passed++;
         for (int c = 1; c <= TMO; c++) begin
            @(negedge clk);
            bus.i_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rdata = 32'hCAFEF00D; bus.m_err = 1'b0;
            bus.m_rvalid = (pass == 1) && (c == TMO);
            #1;
            if (c != TMO) exp_i = 35'h0;
            else if (pass == 0) exp_i = {1'b0, 1'b1, 1'b1, 32'h0};
            else exp_i = {1'b0, 1'b1, 1'b0, 32'hCAFEF00D};
            checks++; if ({i_out, bus.busy} !== {exp_i, 1'b1}) $display("FAIL tmo_rsp[%0d][%0d] got=%h exp=%h", pass, c, {i_out, bus.busy}, {exp_i, 1'b1}); else passed++;
         end
         @(negedge clk);
         clear_inputs();
         #1;
         checks++; if ({bus.busy, i_out} !== 36'h0) $display("FAIL tmo_busy_after[%0d] got=%h exp=0", pass, {bus.busy, i_out}); else passed++;
      end
   endtask

   task automatic test_err_passthru();
      @(negedge clk);
      clear_inputs();
      bus.d_req = 1'b1; bus.d_addr = 32'h500; bus.m_gnt = 1'b1;
      @(negedge clk);
      #1;
      @(negedge clk);
      bus.d_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_err = 1'b1; bus.m_rdata = 32'h55AA55AA;
      #1;
      checks++; if (d_out !== {1'b0, 1'b1, 1'b1, 32'h55AA55AA}) $display("FAIL err_d_out got=%h exp=%h", d_out, {1'b0, 1'b1, 1'b1, 32'h55AA55AA}); else passed++;
      checks++; if (i_out !== 35'h0) $display("FAIL err_i_quiet got=%h exp=0", i_out); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      clear_inputs();
      bus.d_req = 1'b1; bus.d_addr = 32'hABC0; bus.m_gnt = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.d_req = 1'b0; bus.m_gnt = 1'b0;
      @(negedge clk);
      resetb = 1'b0;
      #1;
      checks++; if ({bus.busy, m_bus} !== 71'h0) $display("FAIL rstmid_clear got=%h exp=0", {bus.busy, m_bus}); else passed++;
      @(negedge clk);
      resetb = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         bus.m_rvalid = 1'b1; bus.m_rdata = $urandom; bus.m_err = 1'b1;
         #1;
         checks++; if ({i_out, d_out, bus.busy} !== 71'h0) $display("FAIL rstmid_stray[%0d] got=%h exp=0", k, {i_out, d_out, bus.busy}); else passed++;
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_contention();
      bit exp_d;
      exp_d = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         if (t == 0) begin
            clear_inputs();
            bus.i_req = 1'b1; bus.i_addr = 32'h4000; bus.d_req = 1'b1; bus.d_addr = 32'h8000;
            bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1111_2222;
         end
         #1;
         checks++; if ({bus.busy, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 5'b0) $display("FAIL cont_idle[%0d] got=%b exp=0", t, {bus.busy, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}); else passed++;
         @(negedge clk); #1;
         checks++; if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== {!exp_d, exp_d, 2'b00}) $display("FAIL cont_gnt[%0d] got=%b exp=%b", t, {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}, {!exp_d, exp_d, 2'b00}); else passed++;
         checks++; if (bus.m_addr !== (exp_d ? 32'h8000 : 32'h4000)) $display("FAIL cont_addr[%0d] got=%h exp=%h", t, bus.m_addr, (exp_d ? 32'h8000 : 32'h4000)); else passed++;
         @(negedge clk); #1;
         checks++; if ({bus.i_rvalid, bus.d_rvalid} !== {!exp_d, exp_d}) $display("FAIL cont_rsp[%0d] got=%b exp=%b", t, {bus.i_rvalid, bus.d_rvalid}, {!exp_d, exp_d}); else passed++;
         exp_d = !exp_d;
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_random();
      bit          pend_i, pend_d, mdl_last_d, exp_d, dwe, fire, rv, er;
      logic [31:0] ia, da, dwd, rd;
      logic [3:0]  dst;
      logic [69:0] exp_m;
      logic [34:0] exp_own, own, oth, mask;
      int          g, r;
      @(negedge clk);
      clear_inputs();
      resetb = 1'b0;
      @(negedge clk);
      resetb = 1'b1;
      pend_i = 0; pend_d = 0; mdl_last_d = 0; dwe = 0;
      ia = 32'h0; da = 32'h0; dwd = 32'h0; dst = 4'h0;
      for (int n = 0; n < 40; n++) begin
         if (!pend_i && $urandom_range(0, 1) == 1) begin pend_i = 1; ia = $urandom; end
         if (!pend_d && $urandom_range(0, 1) == 1) begin
            pend_d = 1; da = $urandom; dwe = 1'($urandom_range(0, 1));
            dwd = dwe ? $urandom : 32'h0; dst = 4'($urandom_range(0, 15));
         end
         if (!pend_i && !pend_d) begin pend_i = 1; ia = $urandom; end
         exp_d = pend_d && (!pend_i || !mdl_last_d);
         exp_m = exp_d ? {1'b1, dwe, da, dwd, (dwe ? dst : 4'h0)} : {1'b1, 1'b0, ia, 32'h0, 4'h0};
         g = $urandom_range(0, 3);
         r = $urandom_range(1, 10);
         @(negedge clk);
         bus.i_req = pend_i; bus.i_addr = ia;
         bus.d_req = pend_d; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd; bus.d_wstrb = dst;
         bus.m_gnt = 1'b0; bus.m_rvalid = 1'($urandom_range(0, 1)); bus.m_rdata = $urandom; bus.m_err = 1'($urandom_range(0, 1));
         #1;
         checks++; if ({bus.busy, bus.m_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 6'b0) $display("FAIL rnd_idle[%0d] got=%b exp=0", n, {bus.busy, bus.m_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}); else passed++;
         for (int j = 0; j <= g; j++) begin
            @(negedge clk);
            bus.m_gnt = (j == g); bus.m_rvalid = 1'($urandom_range(0, 1));
            #1;
            checks++; if (m_bus !== exp_m) $display("FAIL rnd_mbus[%0d][%0d] got=%h exp=%h", n, j, m_bus, exp_m); else passed++;
            checks++; if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== {(j == g) && !exp_d, (j == g) && exp_d, 2'b00}) $display("FAIL rnd_gnt[%0d][%0d] got=%b exp=%b", n, j, {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}, {(j == g) && !exp_d, (j == g) && exp_d, 2'b00}); else passed++;
         end
         mdl_last_d = exp_d;
         if (exp_d) pend_d = 0; else pend_i = 0;
         fire = 0;
         for (int c = 1; c <= TMO && !fire; c++) begin
            @(negedge clk);
            rv = (c == r); rd = $urandom; er = 1'($urandom_range(0, 1));
            bus.i_req = pend_i; bus.d_req = pend_d; bus.m_gnt = 1'b0;
            bus.m_rvalid = rv; bus.m_rdata = rd; bus.m_err = er;
            #1;
            fire = rv || (c == TMO);
            exp_own = {1'b0, fire, fire && (rv ? er : 1'b1), ((fire && rv) ? rd : 32'h0)};
            own = exp_d ? d_out : i_out;
            oth = exp_d ? i_out : d_out;
            mask = (exp_d && dwe) ? 35'h7_0000_0000 : 35'h7_FFFF_FFFF;
            checks++; if ((own & mask) !== (exp_own & mask)) $display("FAIL rnd_rsp[%0d][%0d] got=%h exp=%h", n, c, own & mask, exp_own & mask); else passed++;
            checks++; if ({oth, bus.busy, bus.m_req} !== {35'h0, 1'b1, 1'b0}) $display("FAIL rnd_other[%0d][%0d] got=%h exp=%h", n, c, {oth, bus.busy, bus.m_req}, {35'h0, 1'b1, 1'b0}); else passed++;
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      resetb = 1'b0;
      clear_inputs();
      test_reset();
      test_single_fetch();
      test_write_stall();
      test_timeout();
      test_err_passthru();
      test_reset_mid();
      test_contention();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/srv32_mem_arbiter.md
SRV32_MEM_ARBITER -- requirements
Module: srv32_mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, range 0..255: maximum WAIT_RSP cycles before a forced error response; 0 disables the timeout.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port resetb, input, 1, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have ports i_req/i_addr, input, 1/32: instruction-fetch read request and byte address.
REQ-005 The block SHALL have ports i_gnt/i_rvalid/i_rdata/i_err, output, 1/1/32/1: fetch grant, response valid, read data, error.
REQ-006 The block SHALL have ports d_req/d_we/d_addr/d_wdata/d_wstrb, input, 1/1/32/32/4: data request, write enable, address, write data, byte strobes.
REQ-007 The block SHALL have ports d_gnt/d_rvalid/d_rdata/d_err, output, 1/1/32/1: data grant, response valid, read data, error.
REQ-008 The block SHALL have ports m_req/m_we/m_addr/m_wdata/m_wstrb, output, 1/1/32/32/4: the shared memory request bus.
REQ-009 The block SHALL have ports m_gnt/m_rvalid/m_rdata/m_err, input, 1/1/32/1: shared memory grant and response.
REQ-010 The block SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT_GNT and WAIT_RSP, with at most one outstanding transaction.
REQ-012 IDLE: if any request is high, the block SHALL select an owner, register its address/we/wdata/wstrb onto the m_* bus, set m_req=1 and enter WAIT_GNT on the next edge.
REQ-013 If only one of i_req/d_req is high, the block SHALL select that requester.
REQ-014 If both are high, the block SHALL select the requester not granted last (round-robin flag last_d); after reset last_d=0, so data wins the first conflict.
REQ-015 An instruction owner SHALL drive m_we=0, m_wdata=0, m_wstrb=0; a data read (d_we=0) SHALL drive m_wstrb=0.
REQ-016 WAIT_GNT: m_req and all m_* attributes SHALL hold stable until m_gnt=1.
REQ-017 In the m_gnt=1 cycle the block SHALL combinationally assert the owner's gnt (i_gnt or d_gnt) for exactly that cycle, update last_d, and on the next edge clear m_req, clear the timeout counter and enter WAIT_RSP.
REQ-018 A requester's req SHALL remain high until its gnt; a req dropped earlier SHALL NOT cancel the captured transaction.
REQ-019 m_rvalid while in IDLE or WAIT_GNT SHALL be ignored.
REQ-020 WAIT_RSP: on m_rvalid=1 the block SHALL combinationally route m_rdata/m_err to the owner, pulse the owner's rvalid for one cycle and return to IDLE.
REQ-021 The non-owner's rvalid, gnt, rdata and err SHALL be 0 at all times.
REQ-022 Write transactions SHALL also complete on m_rvalid; rdata is don't-care, but err SHALL be forwarded.
REQ-023 Timeout: an 8-bit counter SHALL increment each WAIT_RSP cycle without m_rvalid; when it equals TIMEOUT_CYC (TIMEOUT_CYC≠0), the block SHALL pulse the owner's rvalid with err=1 and rdata=0 and return to IDLE.
REQ-024 If m_rvalid coincides with the timeout cycle, the real response SHALL win (err=m_err).
REQ-025 Minimum latency SHALL be: req at cycle N, m_req at N+1, gnt at N+1 if m_gnt=1, rvalid at N+2 if m_rvalid=1.
REQ-026 A new arbitration SHALL occur only in IDLE, giving one bubble cycle between back-to-back transactions.

Reset
REQ-027 On resetb=0 the block SHALL asynchronously enter IDLE and clear last_d, the timeout counter and all m_* outputs; all gnt/rvalid/rdata/err outputs and busy SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no response pulse; a late m_rvalid after reset release is covered by REQ-019.

Verification
REQ-029 Single fetch: i_req=1, i_addr=0x100, m_gnt=1, m_rvalid next cycle with m_rdata=0xDEADBEEF -> m_addr=0x100, m_we=0, i_gnt one pulse, i_rvalid=1, i_rdata=0xDEADBEEF, d_* outputs all 0.
REQ-030 Contention: i_req=d_req=1 held for three transactions -> grant order data, instr, data; d_gnt precedes i_gnt.
REQ-031 Write: d_we=1, d_addr=0x2000, d_wdata=0x12345678, d_wstrb=0x3; m_gnt delayed 4 cycles -> m_* stable for 4 cycles; d_gnt pulses in the m_gnt cycle; d_rvalid on m_rvalid.
REQ-032 Timeout: TIMEOUT_CYC=8, m_rvalid never asserted -> owner rvalid=1, err=1, rdata=0 after 8 WAIT_RSP cycles, busy falls next cycle; repeat with m_rvalid in the 8th cycle -> err=m_err.
REQ-033 Reset in WAIT_RSP: resetb=0 for one cycle -> busy=0 and m_req=0 immediately; stray m_rvalid afterwards -> no rvalid pulse.
REQ-034 Error pass-through: m_err=1 with m_rvalid on a data read -> d_err=1, d_rvalid=1, i_err=0.
